// File: rtl/i2c_target_pkg.sv
// ============================================================================
// i2c_target_pkg : shared types and constants for the simulated I2C target
// Revision 1.0
// ============================================================================
`default_nettype none

package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_tgt_state_e;

  localparam logic I2cAckBit = 1'b0;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// i2c_bus_sync : SCL/SDA synchronisers and registered bus event detection
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic scl_m, scl_s, scl_q;
  logic sda_m, sda_s, sda_q;
  logic scl_high;

  // SCL high in both samples: an SDA change that coincides with an SCL change
  // is never reported as START or STOP.
  assign scl_high = scl_s & scl_q;
  assign sda_o    = sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_m      <= 1'b1;
      scl_s      <= 1'b1;
      scl_q      <= 1'b1;
      sda_m      <= 1'b1;
      sda_s      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_m      <= scl_i;
      scl_s      <= scl_m;
      scl_q      <= scl_s;
      sda_m      <= sda_i;
      sda_s      <= sda_m;
      sda_q      <= sda_s;
      scl_rise_o <= scl_s & ~scl_q;
      scl_fall_o <= ~scl_s & scl_q;
      start_o    <= scl_high & sda_q & ~sda_s;
      stop_o     <= scl_high & ~sda_q & sda_s;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_target_model.sv
// ============================================================================
// i2c_target_model : I2C target with pointer-addressed, auto-increment regs
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_target_model
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TargetAddr = 7'h50,
  parameter int         NumRegs    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  output logic                       wr_valid_o,
  output logic [$clog2(NumRegs)-1:0] wr_addr_o,
  output logic [7:0]                 wr_data_o
);

  localparam int AW = $clog2(NumRegs);

  logic scl_rise, scl_fall, start, stop, sda;

  i2c_bus_sync u_bus_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop),
    .sda_o      (sda)
  );

  i2c_tgt_state_e state;
  logic [2:0]     bit_cnt;
  logic [6:0]     shreg;
  logic [7:0]     tx;
  logic           ack_phase;
  logic           rw;
  logic [AW-1:0]  ptr;
  logic [7:0]     regs [NumRegs];

  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {shreg, sda};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= '0;
      ack_phase  <= 1'b0;
      rw         <= 1'b0;
      ptr        <= '0;
      sda_oe_o   <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      if (start) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe_o  <= 1'b0;
      end else if (stop) begin
        state     <= ST_IDLE;
        ack_phase <= 1'b0;
        sda_oe_o  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                ack_phase <= 1'b0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == TargetAddr) begin
                    state <= ST_ADDR_ACK;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= ST_IDLE;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= ST_PTR_ACK;
                end else begin
                  regs[ptr]  <= rx_byte;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= ptr;
                  wr_data_o  <= rx_byte;
                  ptr        <= ptr + 1'b1;
                  state      <= ST_WDATA_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            // First fall ends bit 8 and starts the ACK; the second ends the ACK.
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe_o  <= ~I2cAckBit;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == ST_ADDR_ACK && rw) begin
                  tx       <= {regs[ptr][6:0], 1'b0};
                  sda_oe_o <= ~regs[ptr][7];
                  state    <= ST_RDATA;
                end else begin
                  sda_oe_o <= 1'b0;
                  state    <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (last_bit) begin
                sda_oe_o <= 1'b0;
                ptr      <= ptr + 1'b1;
                state    <= ST_RDATA_ACK;
              end else begin
                sda_oe_o <= ~tx[7];
                tx       <= {tx[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise && sda != I2cAckBit) begin
              state <= ST_IDLE;
            end else if (scl_fall) begin
              tx       <= {regs[ptr][6:0], 1'b0};
              sda_oe_o <= ~regs[ptr][7];
              bit_cnt  <= '0;
              state    <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_model.sv
// ============================================================================
// tb_i2c_target_model : directed I2C host bench for i2c_target_model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_i2c_target_model;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       host_low = 1'b0;
  logic       dut_oe;
  logic       sda;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign sda = ~(host_low | dut_oe);

  always #5 clk = ~clk;

  i2c_target_model #(.TargetAddr(7'h50), .NumRegs(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_oe_o   (dut_oe),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] i0;
    logic [3:0] i1;
    logic [7:0] rptr;
    logic [7:0] r0;
    logic [7:0] r1;
  } vec_t;

  wr_t  wq[$];
  int   oe_cnt = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[4];

  always @(negedge clk) begin
    if (wr_valid) wq.push_back('{wr_addr, wr_data});
    if (dut_oe) oe_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    tick(5);
    host_low = ~b;
    tick(5);
    scl = 1'b1;
    tick(5);
    r = sda;
    tick(5);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(5);
    host_low = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(10);
    host_low = 1'b1;
    tick(10);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(5);
    host_low = 1'b1;
    tick(5);
    scl = 1'b1;
    tick(10);
    host_low = 1'b0;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      v[i] = r;
    end
    bit_xfer(~ack, r);
  endtask

  task automatic write_txn(input vec_t v);
    logic ack;
    int   base;
    base = wq.size();
    i2c_start();
    send_byte(8'hA0, ack); check("wr addr ack", 32'(ack), 32'd1);
    send_byte(v.ptr, ack); check("wr ptr ack", 32'(ack), 32'd1);
    send_byte(v.d0, ack);  check("wr d0 ack", 32'(ack), 32'd1);
    send_byte(v.d1, ack);  check("wr d1 ack", 32'(ack), 32'd1);
    i2c_stop();
    check("wr pulse count", 32'(wq.size() - base), 32'd2);
    if (wq.size() >= base + 2) begin
      check("wr0 addr", 32'(wq[base].a), 32'(v.i0));
      check("wr0 data", 32'(wq[base].d), 32'(v.d0));
      check("wr1 addr", 32'(wq[base+1].a), 32'(v.i1));
      check("wr1 data", 32'(wq[base+1].d), 32'(v.d1));
    end
  endtask

  task automatic read_txn(input logic [7:0] ptr, input logic [7:0] e0, input logic [7:0] e1);
    logic       ack;
    logic [7:0] v0, v1;
    i2c_start();
    send_byte(8'hA0, ack); check("rd addr ack", 32'(ack), 32'd1);
    send_byte(ptr, ack);   check("rd ptr ack", 32'(ack), 32'd1);
    i2c_start();
    send_byte(8'hA1, ack); check("rd addr-r ack", 32'(ack), 32'd1);
    recv_byte(1'b1, v0);
    recv_byte(1'b0, v1);
    check("rd byte0", 32'(v0), 32'(e0));
    check("rd byte1", 32'(v1), 32'(e1));
    tick(8);
    check("sda released after nack", 32'(dut_oe), 32'd0);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic r;
    int   base;
    int   oe_base;

    vecs[0] = '{8'h03, 8'hA5, 8'h5A, 4'd3,  4'd4, 8'h03, 8'hA5, 8'h5A};
    vecs[1] = '{8'h0F, 8'h11, 8'h22, 4'd15, 4'd0, 8'h0F, 8'h11, 8'h22};
    vecs[2] = '{8'h47, 8'hC3, 8'h3C, 4'd7,  4'd8, 8'h07, 8'hC3, 8'h3C};
    vecs[3] = '{8'h08, 8'h00, 8'hFF, 4'd8,  4'd9, 8'h07, 8'hC3, 8'h00};

    tick(3);
    check("reset sda_oe", 32'(dut_oe), 32'd0);
    check("reset wr_valid", 32'(wr_valid), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    tick(10);
    check("idle sda_oe", 32'(dut_oe), 32'd0);

    for (int k = 0; k < 4; k++) begin
      write_txn(vecs[k]);
      read_txn(vecs[k].rptr, vecs[k].r0, vecs[k].r1);
    end

    // Wrong address: no ACK, SDA never driven, no writes.
    base    = wq.size();
    oe_base = oe_cnt;
    i2c_start();
    send_byte(8'hA2, ack);
    for (int i = 0; i < 8; i++) bit_xfer(1'b1, r);
    i2c_stop();
    check("wrong addr ack", 32'(ack), 32'd0);
    check("wrong addr oe cycles", 32'(oe_cnt - oe_base), 32'd0);
    check("wrong addr writes", 32'(wq.size() - base), 32'd0);

    // STOP four bits into a data byte: nothing committed, next access normal.
    base = wq.size();
    i2c_start();
    send_byte(8'hA0, ack); check("abort addr ack", 32'(ack), 32'd1);
    send_byte(8'h05, ack); check("abort ptr ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    i2c_stop();
    check("abort writes", 32'(wq.size() - base), 32'd0);
    write_txn('{8'h05, 8'h77, 8'h88, 4'd5, 4'd6, 8'h05, 8'h77, 8'h88});
    read_txn(8'h05, 8'h77, 8'h88);

    // Reset asserted while the target holds the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'hA0 >> i) & 8'h01) != 0, r);
    tick(7);
    check("ack driven before reset", 32'(dut_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset releases sda", 32'(dut_oe), 32'd0);
    tick(2);
    check("reset wr_addr mid", 32'(wr_addr), 32'd0);
    check("reset wr_data mid", 32'(wr_data), 32'd0);
    scl      = 1'b1;
    host_low = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(10);
    read_txn(8'h03, 8'h00, 8'h00);
    read_txn(8'h0F, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
